// File: rtl/gc_fifo_pkg.sv
// Shared definitions for the dual-clock audio sample FIFO: pointer/data widths
// and the Gray/binary pointer conversions used by both clock domains.
package gc_fifo_pkg;

  localparam int unsigned GC_PTR_W     = 8;
  localparam int unsigned GC_DEPTH     = 128;
  localparam int unsigned AUDIO_DATA_W = 24;

  typedef logic [GC_PTR_W-1:0] gc_ptr_t;

  function automatic gc_ptr_t gray2bin(input gc_ptr_t g);
    gc_ptr_t b;
    b[GC_PTR_W-1] = g[GC_PTR_W-1];
    for (int unsigned i = 1; i < GC_PTR_W; i++) begin
      b[GC_PTR_W-1-i] = b[GC_PTR_W-i] ^ g[GC_PTR_W-1-i];
    end
    return b;
  endfunction

  function automatic gc_ptr_t bin2gray(input gc_ptr_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gc_fifo_rd_ctrl_sync.sv
// N-flop bus synchronizer with synchronous active-low clear; the bus must be
// Gray coded so that at most one bit is in transition when sampled.
module gc_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/gc_fifo_rd_ctrl.sv
// Read-side controller of the dual-clock audio FIFO: pointer sync, level/empty,
// RAM fetch and a 2-entry FWFT output buffer. GC_SYNC3_EN selects a 3-flop sync.
module gc_fifo_rd_ctrl
  import gc_fifo_pkg::*;
#(
  parameter int unsigned PTR_W  = GC_PTR_W,
  parameter int unsigned DATA_W = AUDIO_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [PTR_W-1:0]  wr_gc,
  output logic [PTR_W-1:0]  rd_gc,
  output logic              mem_ren,
  output logic [PTR_W-2:0]  mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic [PTR_W-1:0]  level,
  output logic              empty
);

`ifdef GC_SYNC3_EN
  localparam int unsigned SYNC_STAGES = 3;
`else
  localparam int unsigned SYNC_STAGES = 2;
`endif

  logic [PTR_W-1:0]  wr_sync;
  logic [PTR_W-1:0]  wr_bin;
  logic [PTR_W-1:0]  rd_ptr;
  logic [1:0]        cnt;
  logic [1:0]        occ;
  logic              inflight;
  logic              pop;
  logic              push;
  logic [DATA_W-1:0] buf0;
  logic [DATA_W-1:0] buf1;

  gc_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (wr_gc),
    .q    (wr_sync)
  );

  assign wr_bin    = gray2bin(wr_sync);
  assign level     = wr_bin - rd_ptr;
  assign empty     = (level == '0);
  assign mem_raddr = rd_ptr[PTR_W-2:0];

  assign rd_valid = (cnt != 2'd0);
  assign rd_data  = buf0;
  assign pop      = rd_valid && rd_ready;
  assign push     = inflight;

  // An in-flight read reserves a buffer slot, so occupancy never exceeds 2.
  assign occ     = cnt + 2'(inflight);
  assign mem_ren = !empty && ((occ - 2'(pop)) < 2'd2);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr   <= '0;
      rd_gc    <= '0;
      inflight <= 1'b0;
      cnt      <= '0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= mem_ren;
      rd_gc    <= bin2gray(rd_ptr);
      if (mem_ren) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b01: begin
          buf0 <= buf1;
          cnt  <= cnt - 2'd1;
        end
        2'b10: begin
          if (cnt == 2'd0) buf0 <= mem_rdata;
          else             buf1 <= mem_rdata;
          cnt <= cnt + 2'd1;
        end
        2'b11: begin
          // Head leaves and the returning word joins at the tail.
          if (cnt == 2'd1) begin
            buf0 <= mem_rdata;
          end else begin
            buf0 <= buf1;
            buf1 <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gc_fifo_rd_ctrl.sv
// Directed bench for gc_fifo_rd_ctrl: vector table for reset/single word, then
// hand sequences for backpressure, full depth, pointer wrap and mid-stream reset.
module tb_gc_fifo_rd_ctrl;
  import gc_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  wr_gc = '0;
  logic [7:0]  rd_gc;
  logic        mem_ren;
  logic [6:0]  mem_raddr;
  logic [23:0] mem_rdata = '0;
  logic        rd_valid;
  logic [23:0] rd_data;
  logic        rd_ready = 1'b0;
  logic [7:0]  level;
  logic        empty;

  int checks = 0;
  int errors = 0;

  logic [23:0] mem [128];
  logic [6:0]  raddr_q [$];
  logic [7:0]  gc_q [$];
  logic [7:0]  last_gc;

  gc_fifo_rd_ctrl #(.PTR_W(8), .DATA_W(24)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_gc     (wr_gc),
    .rd_gc     (rd_gc),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .level     (level),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_raddr];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts at a negedge with inputs already applied; samples each cycle at negedge+1.
  task automatic drain(input string name, input int n, input logic [7:0] first_ptr,
                       input int budget, input bit b2b);
    int got = 0;
    int cyc = 0;
    bit gap = 1'b0;
    logic [7:0] p = first_ptr;
    while (got < n && cyc < budget) begin
      #1;
      if (rd_valid && rd_ready) begin
        chk($sformatf("%s data[%0d]", name, got), 32'(rd_data), 32'(mem[p[6:0]]));
        p++;
        got++;
      end else if (b2b && got > 0) begin
        gap = 1'b1;
      end
      if (mem_ren) raddr_q.push_back(mem_raddr);
      if (rd_gc !== last_gc) begin
        gc_q.push_back(rd_gc);
        last_gc = rd_gc;
      end
      cyc++;
      @(negedge clk);
    end
    chk({name, " count"}, 32'(got), 32'(n));
    if (b2b) chk({name, " gaps"}, 32'(gap), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    wr_gc = '0;
    rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    logic        rstn;
    logic [7:0]  wr_gc;
    logic        rd_ready;
    logic        e_ren;
    logic [6:0]  e_raddr;
    logic        e_valid;
    logic        chk_d;
    logic [23:0] e_data;
    logic [7:0]  e_level;
    logic        e_empty;
    logic [7:0]  e_gc;
  } vec_t;

  vec_t vt [9];

  initial begin
    int ren_cnt;
    int w;
    bit seen;
    bit bad;
    bit stale;
    logic [23:0] held;
    logic [7:0] exp_gc [4];

    for (int i = 0; i < 128; i++) mem[i] = 24'(i * 24'h010203) ^ 24'h5A5A5A;
    mem[0] = 24'hABCDEF;

    //          rstn wr     rdy ren raddr  vld chkd data        lvl    emp gc
    vt[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 24'h000000, 8'd0, 1'b1, 8'h00};
    vt[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 24'h000000, 8'd0, 1'b1, 8'h00};
    vt[2] = '{1'b1, 8'h00, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 24'h000000, 8'd0, 1'b1, 8'h00};
    vt[3] = '{1'b1, 8'h01, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 24'h000000, 8'd0, 1'b1, 8'h00};
    vt[4] = '{1'b1, 8'h01, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 24'h000000, 8'd0, 1'b1, 8'h00};
    vt[5] = '{1'b1, 8'h01, 1'b1, 1'b1, 7'h00, 1'b0, 1'b1, 24'h000000, 8'd1, 1'b0, 8'h00};
    vt[6] = '{1'b1, 8'h01, 1'b1, 1'b0, 7'h01, 1'b0, 1'b1, 24'h000000, 8'd0, 1'b1, 8'h00};
    vt[7] = '{1'b1, 8'h01, 1'b1, 1'b0, 7'h01, 1'b1, 1'b1, 24'hABCDEF, 8'd0, 1'b1, 8'h01};
    vt[8] = '{1'b1, 8'h01, 1'b1, 1'b0, 7'h01, 1'b0, 1'b0, 24'h000000, 8'd0, 1'b1, 8'h01};

    rstn = 1'b0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      rstn = vt[k].rstn;
      wr_gc = vt[k].wr_gc;
      rd_ready = vt[k].rd_ready;
      #1;
      chk($sformatf("v%0d mem_ren", k), 32'(mem_ren), 32'(vt[k].e_ren));
      chk($sformatf("v%0d mem_raddr", k), 32'(mem_raddr), 32'(vt[k].e_raddr));
      chk($sformatf("v%0d rd_valid", k), 32'(rd_valid), 32'(vt[k].e_valid));
      if (vt[k].chk_d) chk($sformatf("v%0d rd_data", k), 32'(rd_data), 32'(vt[k].e_data));
      chk($sformatf("v%0d level", k), 32'(level), 32'(vt[k].e_level));
      chk($sformatf("v%0d empty", k), 32'(empty), 32'(vt[k].e_empty));
      chk($sformatf("v%0d rd_gc", k), 32'(rd_gc), 32'(vt[k].e_gc));
    end

    // Backpressure: five words behind rd_ptr=1, consumer stalled.
    @(negedge clk);
    rd_ready = 1'b0;
    wr_gc = bin2gray(8'd6);
    ren_cnt = 0;
    seen = 1'b0;
    bad = 1'b0;
    held = '0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (mem_ren) ren_cnt++;
      if (seen && (!rd_valid || rd_data !== held)) bad = 1'b1;
      if (rd_valid && !seen) begin
        seen = 1'b1;
        held = rd_data;
      end
      @(negedge clk);
    end
    chk("bp ren pulses", 32'(ren_cnt), 32'd2);
    chk("bp valid held", 32'(seen && !bad), 32'd1);
    chk("bp held data", 32'(held), 32'(mem[1]));
    chk("bp level", 32'(level), 32'd3);
    rd_ready = 1'b1;
    last_gc = rd_gc;
    drain("bp", 5, 8'd1, 20, 1'b1);
    #1;
    chk("bp empty after", 32'(empty), 32'd1);
    chk("bp valid after", 32'(rd_valid), 32'd0);

    // Full depth from rd_ptr=0.
    do_reset();
    wr_gc = bin2gray(8'd128);
    rd_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("full level", 32'(level), 32'd128);
    chk("full empty", 32'(empty), 32'd0);
    chk("full mem_ren", 32'(mem_ren), 32'd1);
    last_gc = rd_gc;
    drain("full", 128, 8'd0, 200, 1'b1);
    #1;
    chk("full empty after", 32'(empty), 32'd1);
    chk("full level after", 32'(level), 32'd0);

    // Advance rd_ptr to 8'hFE, then cross the wrap.
    wr_gc = bin2gray(8'd254);
    drain("fill", 126, 8'd128, 200, 1'b1);
    #1;
    chk("wrap start gc", 32'(rd_gc), 32'h81);
    raddr_q.delete();
    gc_q.delete();
    last_gc = rd_gc;
    wr_gc = bin2gray(8'd2);
    drain("wrap", 4, 8'hFE, 20, 1'b1);
    #1;
    chk("wrap level", 32'(level), 32'd0);
    chk("wrap ren count", 32'(raddr_q.size()), 32'd4);
    if (raddr_q.size() == 4) begin
      chk("wrap raddr0", 32'(raddr_q[0]), 32'h7E);
      chk("wrap raddr1", 32'(raddr_q[1]), 32'h7F);
      chk("wrap raddr2", 32'(raddr_q[2]), 32'h00);
      chk("wrap raddr3", 32'(raddr_q[3]), 32'h01);
    end
    exp_gc = '{8'h80, 8'h00, 8'h01, 8'h03};
    chk("wrap gc steps", 32'(gc_q.size()), 32'd4);
    if (gc_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("wrap gc[%0d]", i), 32'(gc_q[i]), 32'(exp_gc[i]));
        chk($sformatf("wrap gc[%0d] one bit", i),
            32'($countones(gc_q[i] ^ ((i == 0) ? 8'h81 : gc_q[i-1]))), 32'd1);
      end
    end

    // Reset in the middle of a burst.
    do_reset();
    wr_gc = bin2gray(8'd20);
    rd_ready = 1'b1;
    w = 0;
    #1;
    while (!rd_valid && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("mid valid seen", 32'(rd_valid), 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    wr_gc = '0;
    @(negedge clk);
    #1;
    chk("mid rst valid", 32'(rd_valid), 32'd0);
    chk("mid rst level", 32'(level), 32'd0);
    chk("mid rst empty", 32'(empty), 32'd1);
    chk("mid rst raddr", 32'(mem_raddr), 32'd0);
    chk("mid rst gc", 32'(rd_gc), 32'd0);
    chk("mid rst data", 32'(rd_data), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rd_valid || mem_ren) stale = 1'b1;
      @(negedge clk);
    end
    chk("mid no stale", 32'(stale), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gc_fifo_rd_ctrl.md
Name: gc_fifo_rd_ctrl

Overview:
- Read-side controller of the dual-clock audio sample FIFO; directly downstream consumer of the 8-bit Gray write pointer produced by the write-side Gray counter.
- Synchronizes the remote Gray pointer into the read clock domain and converts it to binary.
- Derives empty and fill level, drives the FIFO RAM read port, and presents data on a valid/ready interface through a 2-entry output buffer.
- Returns its own read pointer in Gray code to the write domain for full detection.

Parameters:
- PTR_W, 8, pointer width in bits; MSB is the wrap bit, so FIFO depth = 2^(PTR_W-1) = 128.
- DATA_W, 24, sample width in bits.

Ports:
- clk  in  1  read-domain clock.
- rstn  in  1  reset: synchronous, active-low.
- wr_gc  in  PTR_W  write pointer in Gray code, from the write clock domain (asynchronous).
- rd_gc  out  PTR_W  registered Gray read pointer, to the write domain.
- mem_ren  out  1  RAM read enable.
- mem_raddr  out  PTR_W-1  RAM read address.
- mem_rdata  in  DATA_W  RAM read data, valid exactly 1 cycle after mem_ren.
- rd_valid  out  1  output data valid.
- rd_data  out  DATA_W  output sample.
- rd_ready  in  1  consumer accepts the sample when rd_valid and rd_ready are both high.
- level  out  PTR_W  words in RAM not yet fetched, range 0..128.
- empty  out  1  high when level == 0.

Behaviour:
- Reset: when rstn is low at the clk edge, every flop clears. Resulting outputs: rd_gc=0, mem_ren=0, mem_raddr=0, rd_valid=0, rd_data=0, level=0, empty=1. Synchronizer flops also clear. A reset asserted mid-transfer discards in-flight and buffered data.
- Synchronizer: wr_gc passes through a 2-flop chain (sync1, sync2). Only sync2 is used downstream.
- Gray-to-binary conversion: wr_bin[MSB] = g[MSB]; wr_bin[i] = wr_bin[i+1] ^ g[i]. Combinational from sync2.
- rd_ptr: PTR_W-bit binary pointer to the next word to fetch. mem_raddr = rd_ptr[PTR_W-2:0].
- level: (wr_bin - rd_ptr) mod 2^PTR_W, combinational from registered values. empty = (level == 0).
- Latency: a wr_gc change reaches level/empty 2 cycles after it is sampled by sync1.
- Output buffer occupancy: occ = (entries held, 0..2) + (1 if a RAM read is in flight).
- Fetch rule: mem_ren = !empty && (occ - pop < 2), where pop = rd_valid && rd_ready in the same cycle.
  - On mem_ren, rd_ptr increments with natural wrap from 255 to 0.
  - The MSB toggle on wrap is required and must not be masked.
- RAM return: mem_rdata captured 1 cycle after mem_ren into the buffer tail.
- Output: rd_data and rd_valid come from the buffer head, first-word-fall-through.
  - rd_valid rises 2 cycles after the first mem_ren from an empty state.
  - Sustained throughput is 1 word/cycle when rd_ready is held high and the FIFO is non-empty.
- Handshake:
  - rd_data is held stable while rd_valid && !rd_ready.
  - rd_valid never deasserts without a pop.
  - Simultaneous push (RAM return) and pop is legal at any occupancy.
- rd_gc: registered rd_ptr ^ (rd_ptr >> 1), updated the cycle after rd_ptr changes. Exactly one bit changes per increment.
- Boundaries:
  - empty with rd_ready high: no fetch, rd_valid stays low once drained.
  - Level = 128: legal (write side full); fetch proceeds normally.
  - Simultaneous wr_gc change and fetch: level reflects both on the next cycle.

Optional Feature:
- Macro GC_SYNC3_EN.
- Defined: 3-flop synchronizer (sync1 → sync2 → sync3), with sync3 feeding the conversion. The level/empty latency becomes 3 cycles after sync1 samples; all other timing is unchanged.
- Undefined: 2-flop synchronizer as described above.

Decomposition:
- Shared package gc_fifo_pkg holds:
  - constants GC_PTR_W=8, GC_DEPTH=128, AUDIO_DATA_W=24;
  - functions gray2bin and bin2gray, also used by the write side.
- One natural sub-module: gc_sync (N-flop synchronizer bus with synchronous active-low clear, width parameterized).

Test Plan:
- Reset: wr_gc=8'h00, drive rstn low 2 cycles then release → empty=1, level=0, rd_valid=0, rd_gc=0, mem_ren=0 throughout.
- Single word: wr_gc 0→1, RAM holds 24'hABCDEF at address 0, rd_ready=1.
  - level=1 at 2 cycles after sampling; mem_ren with mem_raddr=0 in the same cycle.
  - rd_valid high with rd_data=24'hABCDEF 2 cycles later; rd_gc=8'h01 after the pop.
- Backpressure: preload 5 words, rd_ready=0 → at most 2 mem_ren pulses, rd_valid held, rd_data constant.
  - Raise rd_ready → 5 words delivered in order, one per cycle, no duplicates or drops.
- Wrap: start with rd_ptr at 8'hFE, 4 words available → mem_raddr sequence 7E, 7F, 00, 01.
  - rd_gc sequence 81, 80, 00 with exactly one bit change per step; level returns to 0.
- Full depth: wr_gc = bin2gray(128) with rd_ptr=0 → level=128, empty=0.
  - Stream with rd_ready=1 → 128 words delivered back-to-back, then empty=1.
- Mid-stream reset: rstn low during a burst with rd_valid=1 → next cycle rd_valid=0, level=0, rd_ptr=0, and no stale word appears after release.
